bram_port_arbiter: RTL and testbench

- Shares the single data port (port B) of the program/data BRAM between two requesters.
  - Requester 0: riscv_core load/store path.
  - Requester 1: a secondary master, e.g. the video framebuffer reader or a keyboard scancode DMA.
- Registers one access per cycle onto the BRAM port.
- Tracks in-flight reads through the BRAM read pipeline and returns each read word only to the requester that issued it.

---
 rtl/bram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port B between two requesters, r0 wins ties.
// Define BRAM_ARB_STARVE_GUARD_EN to force r1 through after STARVE_LIMIT denials.
module bram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              r0_valid_in,
  output logic              r0_ready_out,
  input  logic [ADDR_W-1:0] r0_addr_in,
  input  logic              r0_we_in,
  input  logic [DATA_W-1:0] r0_wdata_in,
  output logic              r0_rvalid_out,
  output logic [DATA_W-1:0] r0_rdata_out,
  input  logic              r1_valid_in,
  output logic              r1_ready_out,
  input  logic [ADDR_W-1:0] r1_addr_in,
  input  logic              r1_we_in,
  input  logic [DATA_W-1:0] r1_wdata_in,
  output logic              r1_rvalid_out,
  output logic [DATA_W-1:0] r1_rdata_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_en_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in
);

  logic                    forced;
  logic                    r0_xfer;
  logic                    r1_xfer;
  logic                    push_v;
  logic                    push_id;
  logic [READ_LATENCY-1:0] tag_v;
  logic [READ_LATENCY-1:0] tag_id;
  logic                    tail_v;
  logic                    tail_id;

`ifdef BRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      starve_cnt <= '0;
    end else if (r1_xfer || !r1_valid_in) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign forced = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  // strict r0 priority: the limit can never be reached
  assign forced = (STARVE_LIMIT < 0);
`endif

  assign r0_ready_out = rst_in & ~forced;
  assign r1_ready_out = rst_in & (~r0_valid_in | forced);

  assign r0_xfer = r0_valid_in & r0_ready_out;
  assign r1_xfer = r1_valid_in & r1_ready_out & ~r0_xfer;

  assign push_v  = (r0_xfer & ~r0_we_in) | (r1_xfer & ~r1_we_in);
  assign push_id = r1_xfer;

  assign tail_v  = tag_v[READ_LATENCY-1];
  assign tail_id = tag_id[READ_LATENCY-1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_addr_out  <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
    end else if (r0_xfer) begin
      mem_addr_out  <= r0_addr_in;
      mem_en_out    <= 1'b1;
      mem_we_out    <= r0_we_in;
      mem_wdata_out <= r0_wdata_in;
    end else if (r1_xfer) begin
      mem_addr_out  <= r1_addr_in;
      mem_en_out    <= 1'b1;
      mem_we_out    <= r1_we_in;
      mem_wdata_out <= r1_wdata_in;
    end else begin
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
    end
  end

  // tag entries follow each access through the BRAM read pipeline
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= push_v;
      tag_id[0] <= push_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r0_rvalid_out <= 1'b0;
      r1_rvalid_out <= 1'b0;
      r0_rdata_out  <= '0;
      r1_rdata_out  <= '0;
    end else begin
      r0_rvalid_out <= tail_v & ~tail_id;
      r1_rvalid_out <= tail_v & tail_id;
      if (tail_v && !tail_id) r0_rdata_out <= mem_rdata_in;
      if (tail_v && tail_id)  r1_rdata_out <= mem_rdata_in;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of grant, registering and read return.
// Honours BRAM_ARB_STARVE_GUARD_EN to pick the starvation scenario.
module tb_bram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          r0_valid_in, r0_ready_out, r0_we_in, r0_rvalid_out;
  logic [AW-1:0] r0_addr_in;
  logic [DW-1:0] r0_wdata_in, r0_rdata_out;
  logic          r1_valid_in, r1_ready_out, r1_we_in, r1_rvalid_out;
  logic [AW-1:0] r1_addr_in;
  logic [DW-1:0] r1_wdata_in, r1_rdata_out;
  logic [AW-1:0] mem_addr_out;
  logic          mem_en_out, mem_we_out;
  logic [DW-1:0] mem_wdata_out, mem_rdata_in;

  logic [DW-1:0] bram [0:1023];
  logic [DW-1:0] rd_q;

  int n_cmp = 0;
  int n_bad = 0;
  int g0;
  int g1;

  bram_port_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .r0_valid_in(r0_valid_in), .r0_ready_out(r0_ready_out),
    .r0_addr_in(r0_addr_in), .r0_we_in(r0_we_in),
    .r0_wdata_in(r0_wdata_in), .r0_rvalid_out(r0_rvalid_out),
    .r0_rdata_out(r0_rdata_out),
    .r1_valid_in(r1_valid_in), .r1_ready_out(r1_ready_out),
    .r1_addr_in(r1_addr_in), .r1_we_in(r1_we_in),
    .r1_wdata_in(r1_wdata_in), .r1_rvalid_out(r1_rvalid_out),
    .r1_rdata_out(r1_rdata_out),
    .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out),
    .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: data for an address seen in cycle M is on mem_rdata_in in M+1
  always @(posedge clk_in) begin
    if (mem_en_out) begin
      if (mem_we_out) bram[mem_addr_out[9:0]] <= mem_wdata_out;
      else            rd_q <= bram[mem_addr_out[9:0]];
    end
  end
  assign mem_rdata_in = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    r0_valid_in = 0; r0_addr_in = '0; r0_we_in = 0; r0_wdata_in = '0;
    r1_valid_in = 0; r1_addr_in = '0; r1_we_in = 0; r1_wdata_in = '0;
  endtask

  task automatic drive0(input logic v, input logic [AW-1:0] a,
                        input logic we, input logic [DW-1:0] d);
    r0_valid_in = v; r0_addr_in = a; r0_we_in = we; r0_wdata_in = d;
  endtask

  task automatic drive1(input logic v, input logic [AW-1:0] a,
                        input logic we, input logic [DW-1:0] d);
    r1_valid_in = v; r1_addr_in = a; r1_we_in = we; r1_wdata_in = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = '0;
    bram[16] = 32'hDEADBEEF;
    bram[1]  = 32'h11111111;
    bram[2]  = 32'h22222222;
    for (int k = 0; k < 6; k++) bram[32+k] = 32'hA0000000 + k;

    // reset
    idle();
    rst_in = 1;
    #2 rst_in = 0;
    drive0(1, 16'h0010, 0, '0);
    drive1(1, 16'h0002, 0, '0);
    #1;
    chk("rst_r0_ready", r0_ready_out, 0);
    chk("rst_r1_ready", r1_ready_out, 0);
    chk("rst_mem_en", mem_en_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_mem_wdata", mem_wdata_out, 0);
    chk("rst_rvalid", {r0_rvalid_out, r1_rvalid_out}, 0);
    chk("rst_rdata", {r0_rdata_out, r1_rdata_out}, 0);
    tick();
    tick();
    chk("rst_hold_en", {mem_en_out, mem_we_out}, 0);
    idle();
    rst_in = 1;

    // single read from r0
    drive0(1, 16'h0010, 0, '0);
    #1;
    chk("t1_r0_ready", r0_ready_out, 1);
    chk("t1_r1_ready", r1_ready_out, 0);
    tick();
    idle();
    #1;
    chk("t1_mem_addr", mem_addr_out, 16'h0010);
    chk("t1_mem_en_we", {mem_en_out, mem_we_out}, 2'b10);
    tick();
    chk("t1_rvalid_early", r0_rvalid_out, 0);
    tick();
    chk("t1_r0_rvalid", r0_rvalid_out, 1);
    chk("t1_r0_rdata", r0_rdata_out, 32'hDEADBEEF);
    chk("t1_r1_rvalid", r1_rvalid_out, 0);
    tick();
    chk("t1_rvalid_pulse", r0_rvalid_out, 0);
    chk("t1_rdata_hold", r0_rdata_out, 32'hDEADBEEF);
    chk("t1_mem_en_idle", mem_en_out, 0);

    // r1 write then read
    tick();
    drive1(1, 16'h0200, 1, 32'h12345678);
    #1;
    chk("t2_r1_ready", r1_ready_out, 1);
    tick();
    drive1(1, 16'h0200, 0, '0);
    #1;
    chk("t2_mem_we", {mem_en_out, mem_we_out}, 2'b11);
    chk("t2_mem_addr", mem_addr_out, 16'h0200);
    chk("t2_mem_wdata", mem_wdata_out, 32'h12345678);
    tick();
    idle();
    #1;
    chk("t2_mem_rd", {mem_en_out, mem_we_out}, 2'b10);
    tick();
    chk("t2_no_wr_rvalid", {r0_rvalid_out, r1_rvalid_out}, 0);
    tick();
    chk("t2_r1_rvalid", {r0_rvalid_out, r1_rvalid_out}, 2'b01);
    chk("t2_r1_rdata", r1_rdata_out, 32'h12345678);

    // contention: both read for 3 cycles, then r0 drops
    tick();
    g0 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      drive0(c < 3, 16'h0001, 0, '0);
      drive1(c <= 3, 16'h0002, 0, '0);
      #1;
      if (r0_valid_in && r0_ready_out) g0++;
      if (c <= 3) chk($sformatf("t3_r1_ready_c%0d", c), r1_ready_out, c == 3);
      chk($sformatf("t3_r0_rvalid_c%0d", c), r0_rvalid_out, c >= 3 && c <= 5);
      chk($sformatf("t3_r1_rvalid_c%0d", c), r1_rvalid_out, c == 6);
      if (c >= 3 && c <= 5) chk("t3_r0_rdata", r0_rdata_out, 32'h11111111);
      if (c == 6) chk("t3_r1_rdata", r1_rdata_out, 32'h22222222);
    end
    chk("t3_r0_grants", g0, 3);

    // alternating reads every cycle
    tick();
    for (int c = 0; c < 10; c++) begin
      int k;
      logic e0, e1;
      if (c > 0) tick();
      idle();
      if (c < 6) begin
        if (c % 2 == 0) drive0(1, AW'(32 + c), 0, '0);
        else            drive1(1, AW'(32 + c), 0, '0);
      end
      #1;
      k  = c - 3;
      e0 = (c >= 3) && (c <= 8) && (k % 2 == 0);
      e1 = (c >= 3) && (c <= 8) && (k % 2 == 1);
      chk($sformatf("t4_r0_rvalid_c%0d", c), r0_rvalid_out, e0);
      chk($sformatf("t4_r1_rvalid_c%0d", c), r1_rvalid_out, e1);
      if (e0) chk($sformatf("t4_r0_rdata_c%0d", c), r0_rdata_out, 32'hA0000000 + k);
      if (e1) chk($sformatf("t4_r1_rdata_c%0d", c), r1_rdata_out, 32'hA0000000 + k);
      if (c == 4) chk("t4_r0_rdata_hold", r0_rdata_out, 32'hA0000000);
    end

    // reset while a read is in flight
    tick();
    drive0(1, 16'h0010, 0, '0);
    #1;
    chk("t5_r0_ready", r0_ready_out, 1);
    tick();
    idle();
    rst_in = 0;
    #1;
    chk("t5_rst_mem", {mem_en_out, mem_we_out, mem_addr_out}, 0);
    chk("t5_rst_rdata", {r0_rdata_out, r1_rdata_out}, 0);
    chk("t5_rst_ready", {r0_ready_out, r1_ready_out}, 0);
    tick();
    chk("t5_rst_rvalid", {r0_rvalid_out, r1_rvalid_out}, 0);
    tick();
    rst_in = 1;
    drive0(1, 16'h0020, 0, '0);
    #1;
    chk("t5_dropped_rvalid", {r0_rvalid_out, r1_rvalid_out}, 0);
    chk("t5_post_ready", r0_ready_out, 1);
    tick();
    idle();
    #1;
    chk("t5_post_mem", {mem_en_out, mem_addr_out}, {1'b1, 16'h0020});
    chk("t5_post_rvalid1", r0_rvalid_out, 0);
    tick();
    chk("t5_post_rvalid2", r0_rvalid_out, 0);
    tick();
    chk("t5_post_rvalid3", r0_rvalid_out, 1);
    chk("t5_post_rdata", r0_rdata_out, 32'hA0000000);

    // starvation
    tick();
`ifdef BRAM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      drive0(1, 16'h0001, 0, '0);
      drive1(1, 16'h0002, 0, '0);
      #1;
      chk($sformatf("t6_r1_ready_c%0d", c), r1_ready_out, c == 8);
      chk($sformatf("t6_r0_ready_c%0d", c), r0_ready_out, c != 8);
      if (c == 9) chk("t6_forced_addr", mem_addr_out, 16'h0002);
    end
`else
    g1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) tick();
      drive0(1, 16'h0001, 0, '0);
      drive1(1, 16'h0002, 0, '0);
      #1;
      if (r1_valid_in && r1_ready_out) g1++;
    end
    chk("t6_r1_grants", g1, 0);
`endif
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
